prog_mealy_fsm: RTL and testbench
=================================

Name: prog_mealy_fsm

Overview:
Table-programmable Mealy state machine with a built-in expected-value checker. It generalises the fixed 5-state/5-symbol harness FSM to parametrised state count, input alphabet and output width. The next-state/output table is loaded through a config port, and the machine is then stepped one input symbol per handshake. It is the DUT-side engine for FSM conformance runs: it flags illegal transitions and counts mismatches against the expected state and output.

Parameters:
NUM_STATES, 5, number of legal states (2..16)
STATE_W, 3, state encoding width; 2^STATE_W >= NUM_STATES
NUM_INPUTS, 5, number of legal input symbols (1..16)
IN_W, 3, input symbol width; 2^IN_W >= NUM_INPUTS
OUT_W, 4, Mealy output width
RESET_STATE, 0, state entered on reset and on illegal transition
CNT_W, 8, mismatch counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
run  in  1  1 = step mode, 0 = config mode
cfg_we  in  1  table write strobe
cfg_state  in  STATE_W  table row (current state)
cfg_in  in  IN_W  table column (input symbol)
cfg_next  in  STATE_W  programmed next state
cfg_out  in  OUT_W  programmed output
cfg_err  out  1  registered pulse: rejected config write
in_valid  in  1  input symbol present this cycle
in  in  IN_W  input symbol
exp_valid  in  1  exp_state/exp_out valid for this step
exp_state  in  STATE_W  expected next state
exp_out  in  OUT_W  expected output
state  out  STATE_W  current state (registered)
out  out  OUT_W  Mealy output (combinational)
step  out  1  registered pulse: a transition was taken last cycle
illegal  out  1  registered pulse: last step hit an undefined entry
mismatch  out  1  registered pulse: last checked step mismatched
mismatch_cnt  out  CNT_W  saturating mismatch count

Behaviour:
- Reset (synchronous, overrides everything): state=RESET_STATE; all table entries are invalidated (per-entry valid bit=0); cfg_err, step, illegal, mismatch=0; mismatch_cnt=0. Next/out fields need not be cleared.
- Table: NUM_STATES x NUM_INPUTS entries of {valid, next, out}, held in flops.
- Config writes: a write is accepted when cfg_we=1, run=0, cfg_state<NUM_STATES, cfg_in<NUM_INPUTS and cfg_next<NUM_STATES. An accepted write sets the entry valid and stores next/out on the clock edge. Any other cfg_we=1 cycle leaves the table unchanged and sets cfg_err=1 for one cycle. A later write to the same entry overwrites it.
- Step condition: fire = run & in_valid. When fire=0, state holds, out=0 and the pulses deassert.
- Entry lookup when fire=1: the entry is legal iff in<NUM_INPUTS and the entry at [state][in] is valid.
  - Legal entry: out = entry.out, combinational in the same cycle (Mealy). On the edge, state <= entry.next.
  - Illegal entry: out=0. On the edge, state <= RESET_STATE and illegal=1.
  - step=1 on the following cycle in either case.
- Checker (when fire & exp_valid): compare the computed next state (RESET_STATE if illegal) with exp_state, and out with exp_out.
  - Any difference: mismatch=1 the next cycle, and mismatch_cnt increments, saturating at 2^CNT_W-1.
  - When exp_valid=0, no check is made.
- Config mode: while run=0, state holds and no steps occur. cfg_we is ignored (cfg_err pulse) while run=1.
- Throughput: one step per cycle, back-to-back; output latency 0 cycles, state latency 1 cycle.
- Reset asserted mid-run: the step in that cycle is discarded and the table must be reprogrammed.

Test Plan:
1. After reset, run=0: program the 5x5 table with next=(s+i)%5, out={s,i[0]}. Set run=1 and drive in sequence 1,2,3 from state 0 -> state 1,3,1; out 4'h1,4'h2,4'h7 in the step cycles; step pulses for 3 cycles.
2. Step with in=6 (>=NUM_INPUTS) from state 3 -> out=0, state=0 next cycle, illegal=1 for one cycle. Repeat with an unprogrammed entry -> same response.
3. With exp_valid=1 and exp_out deliberately wrong on 2 of 4 steps -> mismatch pulses exactly twice, mismatch_cnt=2. With exp_valid=0 -> count unchanged.
4. Config errors: cfg_we with run=1 -> cfg_err=1 and the table is unchanged; cfg_state=5 -> cfg_err=1; cfg_next=7 -> cfg_err=1.
5. Force 300 mismatches with CNT_W=8 -> mismatch_cnt saturates at 255.
6. Assert reset mid-run with in_valid=1 -> state=0 the next cycle, mismatch_cnt=0, all entries invalid (the next step raises illegal).

Source files
------------

// File: rtl/prog_mealy_fsm.sv
// Table-programmable Mealy FSM with an expected-value checker.
// The next-state/output table is loaded in config mode; the machine then steps one symbol per in_valid cycle.
module prog_mealy_fsm #(
    parameter int unsigned NUM_STATES  = 5,
    parameter int unsigned STATE_W     = 3,
    parameter int unsigned NUM_INPUTS  = 5,
    parameter int unsigned IN_W        = 3,
    parameter int unsigned OUT_W       = 4,
    parameter int unsigned RESET_STATE = 0,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               cfg_we,
    input  logic [STATE_W-1:0] cfg_state,
    input  logic [IN_W-1:0]    cfg_in,
    input  logic [STATE_W-1:0] cfg_next,
    input  logic [OUT_W-1:0]   cfg_out,
    output logic               cfg_err,
    input  logic               in_valid,
    input  logic [IN_W-1:0]    in,
    input  logic               exp_valid,
    input  logic [STATE_W-1:0] exp_state,
    input  logic [OUT_W-1:0]   exp_out,
    output logic [STATE_W-1:0] state,
    output logic [OUT_W-1:0]   out,
    output logic               step,
    output logic               illegal,
    output logic               mismatch,
    output logic [CNT_W-1:0]   mismatch_cnt
);
    localparam logic [STATE_W-1:0] RST_ST  = STATE_W'(RESET_STATE);
    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};
    // One extra bit so a full power-of-two range still compares correctly.
    localparam logic [STATE_W:0]   NS_LIM  = (STATE_W + 1)'(NUM_STATES);
    localparam logic [IN_W:0]      NI_LIM  = (IN_W + 1)'(NUM_INPUTS);

    logic               tbl_valid [NUM_STATES][NUM_INPUTS];
    logic [STATE_W-1:0] tbl_next  [NUM_STATES][NUM_INPUTS];
    logic [OUT_W-1:0]   tbl_out   [NUM_STATES][NUM_INPUTS];

    logic               cfg_ok;
    logic               fire;
    logic               legal;
    logic               chk_bad;
    logic               hit_valid;
    logic [STATE_W-1:0] hit_next;
    logic [OUT_W-1:0]   hit_out;
    logic [STATE_W-1:0] next_state;

    // Config write acceptance: config mode and all fields in range.
    always_comb begin : cfg_accept
        cfg_ok = cfg_we && !run
              && ({1'b0, cfg_state} < NS_LIM)
              && ({1'b0, cfg_in} < NI_LIM)
              && ({1'b0, cfg_next} < NS_LIM);
    end

    // Entry lookup by compare; out-of-range symbols match nothing.
    always_comb begin : lookup
        hit_valid = 1'b0;
        hit_next  = RST_ST;
        hit_out   = '0;
        for (int s = 0; s < NUM_STATES; s++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (state == STATE_W'(s) && in == IN_W'(i)) begin
                    hit_valid = tbl_valid[s][i];
                    hit_next  = tbl_next[s][i];
                    hit_out   = tbl_out[s][i];
                end
            end
        end
    end

    // Next state, Mealy output and checker compare.
    always_comb begin : step_logic
        fire       = run && in_valid;
        legal      = fire && hit_valid;
        next_state = state;
        out        = '0;
        chk_bad    = 1'b0;
        if (fire) begin
            next_state = legal ? hit_next : RST_ST;
            out        = legal ? hit_out : '0;
            chk_bad    = exp_valid && ((next_state != exp_state) || (out != exp_out));
        end
    end

    // State register, status pulses, counter and entry valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RST_ST;
            step         <= 1'b0;
            illegal      <= 1'b0;
            mismatch     <= 1'b0;
            cfg_err      <= 1'b0;
            mismatch_cnt <= '0;
            for (int s = 0; s < NUM_STATES; s++) begin
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    tbl_valid[s][i] <= 1'b0;
                end
            end
        end else begin
            state    <= next_state;
            step     <= fire;
            illegal  <= fire && !legal;
            mismatch <= chk_bad;
            cfg_err  <= cfg_we && !cfg_ok;
            if (chk_bad && mismatch_cnt != CNT_MAX) begin
                mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            end
            for (int s = 0; s < NUM_STATES; s++) begin
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    if (cfg_ok && cfg_state == STATE_W'(s) && cfg_in == IN_W'(i)) begin
                        tbl_valid[s][i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Entry payload; only meaningful while its valid bit is set, so no reset.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_STATES; s++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (cfg_ok && cfg_state == STATE_W'(s) && cfg_in == IN_W'(i)) begin
                    tbl_next[s][i] <= cfg_next;
                    tbl_out[s][i]  <= cfg_out;
                end
            end
        end
    end
endmodule

// File: tb/tb_prog_mealy_fsm.sv
// Self-checking bench for prog_mealy_fsm: directed vector table, hand sequences
// and random stepping against an array-based reference model.
module tb_prog_mealy_fsm;
    localparam int NS = 5;
    localparam int SW = 3;
    localparam int NI = 5;
    localparam int IW = 3;
    localparam int OW = 4;
    localparam int CW = 8;
    localparam int CNT_SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, run, cfg_we, cfg_err, in_valid, exp_valid;
    logic [SW-1:0] cfg_state, cfg_next, exp_state, state;
    logic [IW-1:0] cfg_in, sym;
    logic [OW-1:0] cfg_out, exp_out, dout;
    logic          step, illegal, mismatch;
    logic [CW-1:0] mismatch_cnt;

    always #5 clk = ~clk;

    prog_mealy_fsm #(
        .NUM_STATES(NS), .STATE_W(SW), .NUM_INPUTS(NI), .IN_W(IW),
        .OUT_W(OW), .RESET_STATE(0), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .cfg_we(cfg_we),
        .cfg_state(cfg_state), .cfg_in(cfg_in), .cfg_next(cfg_next),
        .cfg_out(cfg_out), .cfg_err(cfg_err), .in_valid(in_valid), .in(sym),
        .exp_valid(exp_valid), .exp_state(exp_state), .exp_out(exp_out),
        .state(state), .out(dout), .step(step), .illegal(illegal),
        .mismatch(mismatch), .mismatch_cnt(mismatch_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the programmed table as plain arrays.
    bit m_valid [NS][NI];
    int m_next  [NS][NI];
    int m_out   [NS][NI];
    int m_state;
    int m_cnt;

    typedef struct {
        bit in_valid;
        int in_sym;
        int exp_out;
        int exp_state;
        bit exp_step;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++)
            for (int i = 0; i < NI; i++) m_valid[s][i] = 1'b0;
        m_state = 0;
        m_cnt   = 0;
    endtask

    function automatic void predict(input bit fire, input int isym,
                                    output int e_next, output int e_out, output bit e_ill);
        e_next = m_state;
        e_out  = 0;
        e_ill  = 1'b0;
        if (fire) begin
            if (isym < NI && m_valid[m_state][isym]) begin
                e_next = m_next[m_state][isym];
                e_out  = m_out[m_state][isym];
            end else begin
                e_next = 0;
                e_ill  = 1'b1;
            end
        end
    endfunction

    task automatic drive(input bit r, input bit rn, input bit iv, input int isym,
                         input bit ev, input int es, input int eo);
        reset = r; run = rn; in_valid = iv; sym = IW'(isym);
        exp_valid = ev; exp_state = SW'(es); exp_out = OW'(eo); cfg_we = 1'b0;
    endtask

    task automatic cfg(input bit rn, input int s, input int i, input int n, input int o);
        reset = 1'b0; run = rn; in_valid = 1'b0; exp_valid = 1'b0; cfg_we = 1'b1;
        cfg_state = SW'(s); cfg_in = IW'(i); cfg_next = SW'(n); cfg_out = OW'(o);
    endtask

    // One clock with inputs already applied; checks comb out then registered outputs.
    task automatic tick(input string tag);
        int e_next, e_out;
        bit e_ill, e_mm, e_cerr, e_step, wr_ok;
        e_step = run && in_valid;
        predict(e_step, int'(sym), e_next, e_out, e_ill);
        e_mm   = e_step && exp_valid && (e_next != int'(exp_state) || e_out != int'(exp_out));
        wr_ok  = cfg_we && !run && int'(cfg_state) < NS && int'(cfg_in) < NI && int'(cfg_next) < NS;
        e_cerr = cfg_we && !wr_ok;
        @(negedge clk);
        if (!reset) chk({tag, " out"}, int'(dout), e_out);
        @(posedge clk);
        #1;
        if (reset) begin
            model_reset();
            e_step = 1'b0; e_ill = 1'b0; e_mm = 1'b0; e_cerr = 1'b0;
        end else begin
            if (wr_ok) begin
                m_valid[cfg_state][cfg_in] = 1'b1;
                m_next[cfg_state][cfg_in]  = int'(cfg_next);
                m_out[cfg_state][cfg_in]   = int'(cfg_out);
            end
            m_state = e_next;
            if (e_mm && m_cnt < CNT_SAT) m_cnt++;
        end
        chk({tag, " state"}, int'(state), m_state);
        chk({tag, " step"}, int'(step), int'(e_step));
        chk({tag, " illegal"}, int'(illegal), int'(e_ill));
        chk({tag, " mismatch"}, int'(mismatch), int'(e_mm));
        chk({tag, " cnt"}, int'(mismatch_cnt), m_cnt);
        chk({tag, " cfg_err"}, int'(cfg_err), int'(e_cerr));
    endtask

    initial begin
        int en, eo, es2, eo2;
        bit ei, rn, iv;
        int isym;

        vecs[0] = '{1'b1, 1, 4'h1, 1, 1'b1};
        vecs[1] = '{1'b1, 2, 4'h2, 3, 1'b1};
        vecs[2] = '{1'b1, 3, 4'h7, 1, 1'b1};
        vecs[3] = '{1'b0, 1, 4'h0, 1, 1'b0};

        reset = 1'b1; run = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; exp_valid = 1'b0;
        cfg_state = '0; cfg_in = '0; cfg_next = '0; cfg_out = '0;
        sym = '0; exp_state = '0; exp_out = '0;
        model_reset();
        tick("reset");

        // Program next=(s+i)%5, out={s,i[0]}.
        for (int s = 0; s < NS; s++)
            for (int i = 0; i < NI; i++) begin
                cfg(1'b0, s, i, (s + i) % NS, s * 2 + (i & 1));
                tick("prog");
            end

        // Directed vectors from state 0.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, vecs[k].in_valid, vecs[k].in_sym, 1'b0, 0, 0);
            @(negedge clk);
            chk($sformatf("vec%0d out", k), int'(dout), vecs[k].exp_out);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d state", k), int'(state), vecs[k].exp_state);
            chk($sformatf("vec%0d step", k), int'(step), int'(vecs[k].exp_step));
            m_state = vecs[k].exp_state;
        end

        // Out-of-range symbol from state 3.
        drive(1'b0, 1'b1, 1'b1, 2, 1'b0, 0, 0);
        tick("to3");
        drive(1'b0, 1'b1, 1'b1, 6, 1'b0, 0, 0);
        tick("badsym");
        chk("badsym illegal", int'(illegal), 1);
        drive(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 0);
        tick("badsym idle");

        // Config errors: write during run leaves table alone; out-of-range fields.
        cfg(1'b1, 0, 0, 4, 15);
        tick("cfg_run");
        drive(1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 0);
        tick("cfg_run chk");
        cfg(1'b0, 5, 0, 0, 0);
        tick("cfg_st5");
        cfg(1'b0, 1, 1, 7, 0);
        tick("cfg_nx7");
        cfg(1'b0, 1, 5, 0, 0);
        tick("cfg_in5");

        // Four checked steps, two with wrong exp_out; then unchecked steps.
        for (int k = 0; k < 4; k++) begin
            predict(1'b1, k + 1, en, eo, ei);
            drive(1'b0, 1'b1, 1'b1, k + 1, 1'b1, en, (k % 2 == 1) ? (eo ^ 1) : eo);
            tick("chk4");
        end
        chk("cnt after 4", int'(mismatch_cnt), 2);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b1, k, 1'b0, 7, 15);
            tick("noexp");
        end
        chk("cnt unchecked", int'(mismatch_cnt), 2);

        // Saturation.
        for (int k = 0; k < 300; k++) begin
            predict(1'b1, k % NI, en, eo, ei);
            drive(1'b0, 1'b1, 1'b1, k % NI, 1'b1, (en + 1) % NS, eo);
            tick("sat");
        end
        chk("cnt saturated", int'(mismatch_cnt), 255);

        // Reset mid-step clears table and counter.
        drive(1'b1, 1'b1, 1'b1, 1, 1'b1, 3, 3);
        tick("midreset");
        chk("midreset cnt", int'(mismatch_cnt), 0);
        drive(1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 0);
        tick("unprog");
        chk("unprog illegal", int'(illegal), 1);

        // Partial random table, then random stepping and config traffic.
        for (int s = 0; s < NS; s++)
            for (int i = 0; i < NI; i++)
                if ($urandom_range(0, 9) < 6) begin
                    cfg(1'b0, s, i, $urandom_range(0, NS - 1), $urandom_range(0, 15));
                    tick("rprog");
                end
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                cfg($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 15));
            end else begin
                rn   = ($urandom_range(0, 7) != 0);
                iv   = ($urandom_range(0, 3) != 0);
                isym = $urandom_range(0, 6);
                predict(rn && iv, isym, en, eo, ei);
                es2 = en;
                eo2 = eo;
                if ($urandom_range(0, 3) == 0) begin
                    es2 = $urandom_range(0, NS - 1);
                    eo2 = $urandom_range(0, 15);
                end
                drive(1'b0, rn, iv, isym, $urandom_range(0, 1), es2, eo2);
            end
            tick("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
